// File: rtl/wb_pkg.sv
// Shared Wishbone types for the two-master arbiter.
//   arb_state_t : arbiter FSM encoding (also exported on the debug port)
//   wb_req_t    : one master's request bundle {addr, dat, sel, cyc, stb, we}
//   WB_AW/WB_DW : address and data widths; WB_SW is the byte-select width
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
    logic             cyc;
    logic             stb;
    logic             we;
  } wb_req_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts consecutive stalled strobe cycles.
//   clk_i, rst_i : clock, synchronous active-high reset
//   run          : a strobe is outstanding this cycle without ack
//   clear        : restart the count (ack seen, strobe low, or no grant)
//   expired      : count has reached TIMEOUT-1; the current stalled cycle is the last one
// The count saturates at the terminal value, so it can never wrap.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int              CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      count <= '0;
    end else if (run && (count != TERM)) begin
      count <= count + 1'b1;
    end
  end

  // Registered terminal flag: keeps the err/stb-kill path free of any
  // combinational dependence on s_ack_i (the slave may ack combinationally).
  assign expired = (count == TERM);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter, round-robin, grant held for
// the whole bus cycle, with a stall watchdog that ends hung cycles with err.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   m{0,1}_*_i              : master requests (addr, dat, sel, cyc, stb, we)
//   m{0,1}_dat_o            : read data, s_dat_i broadcast to both masters
//   m{0,1}_ack_o/err_o      : termination, only to the granted master
//   s_*_o                   : request to the slave
//   s_dat_i, s_ack_i        : slave read data and ack (ack may be combinational)
//   dbg_state               : current arbiter state
//
// Handshake: a transfer is offered while cyc&stb are high on s_*; it completes in
// the cycle s_ack_i is high (that is the only "ready"), and the master may change
// its request only after the clock edge that ends that cycle. err replaces ack
// when the watchdog fires; the two are never high together.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WB_AW-1:0] m0_addr_i,
  input  logic [WB_DW-1:0] m0_dat_i,
  input  logic [WB_SW-1:0] m0_sel_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  output logic [WB_DW-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [WB_AW-1:0] m1_addr_i,
  input  logic [WB_DW-1:0] m1_dat_i,
  input  logic [WB_SW-1:0] m1_sel_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  output logic [WB_DW-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [WB_AW-1:0] s_addr_o,
  output logic [WB_DW-1:0] s_dat_o,
  output logic [WB_SW-1:0] s_sel_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  input  logic [WB_DW-1:0] s_dat_i,
  input  logic             s_ack_i,
  output arb_state_t       dbg_state
);

  arb_state_t state, state_nxt;
  logic       last_grant, last_grant_nxt;

  wb_req_t m0_req, m1_req, sel_req;
  logic    granted, owner, stb_raw, expired, err, wd_run, wd_clear;

  assign m0_req = {m0_addr_i, m0_dat_i, m0_sel_i, m0_cyc_i, m0_stb_i, m0_we_i};
  assign m1_req = {m1_addr_i, m1_dat_i, m1_sel_i, m1_cyc_i, m1_stb_i, m1_we_i};

  assign granted = (state == GNT0) || (state == GNT1);
  assign owner   = (state == GNT1);
  assign sel_req = granted ? (owner ? m1_req : m0_req) : '0;

  // Request -> slave path only exists through the registered grant state.
  assign stb_raw  = sel_req.cyc & sel_req.stb;
  assign err      = stb_raw & expired & ~rst_i;

  assign s_addr_o = sel_req.addr;
  assign s_dat_o  = sel_req.dat;
  assign s_sel_o  = sel_req.sel;
  assign s_we_o   = sel_req.we;
  // Reset kills the bus in the same cycle so no late ack can complete.
  assign s_cyc_o  = sel_req.cyc & ~rst_i;
  assign s_stb_o  = stb_raw & ~expired & ~rst_i;

  assign m0_ack_o = (state == GNT0) & s_ack_i & s_stb_o;
  assign m1_ack_o = (state == GNT1) & s_ack_i & s_stb_o;
  assign m0_err_o = (state == GNT0) & err;
  assign m1_err_o = (state == GNT1) & err;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign dbg_state = state;

  // On the expiry cycle s_stb_o is already forced low, so run drops and the
  // counter clears on its own; ABORT/IDLE also keep it cleared.
  assign wd_run   = s_stb_o & ~s_ack_i;
  assign wd_clear = ~wd_run;

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run    (wd_run),
    .clear  (wd_clear),
    .expired(expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // last_grant is recorded when the grant is issued. IDLE is only re-entered
  // after that master releases, so arbitration sees the same value as if it
  // were recorded on release, and ABORT can use it to know whose cyc to watch.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
          state_nxt      = GNT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt      = GNT1;
          last_grant_nxt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (err) begin
          state_nxt = ABORT;
        end else if (!sel_req.cyc) begin
          state_nxt = IDLE;
        end
      end
      ABORT: begin
        if (!(last_grant ? m1_cyc_i : m0_cyc_i)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;
  import wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUT signals ----------------
  logic [31:0] m0_addr_i, m0_dat_i, m1_addr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_addr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  arb_state_t  dbg_state;

  wb_arbiter2 #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .dbg_state(dbg_state)
  );

  // ---------------- RAM slave model ----------------
  function automatic logic [31:0] init_word(input int i);
    return {8'hA5, 8'(i), 8'h5A, ~8'(i)};
  endfunction

  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  logic        ack_en = 1'b1;
  int          lat = 0;
  int          wait_cnt = 0;

  assign s_ack_i = ack_en && s_stb_o && (wait_cnt == lat);
  assign s_dat_i = mem[s_addr_o[9:2]];

  always @(posedge clk) begin
    if (rst_i && !mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (s_stb_o && s_ack_i && s_we_o) begin
      for (int b = 0; b < 4; b++)
        if (s_sel_o[b]) mem[s_addr_o[9:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
    end
    if (s_stb_o && !s_ack_i) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          failures = 0;
  logic [0:0]  exp_q[$];          // expected order of serviced masters
  logic [31:0] ref_mem [256];
  logic        last_served;       // master that most recently held the bus
  int          ack_cyc [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Round-robin rule at transaction level: a lone requester is served; when both
  // ask at once, the one not served last goes first and the other follows.
  task automatic expect_round(input logic r0, input logic r1);
    logic first;
    if (r0 && r1) begin
      first = ~last_served;
      exp_q.push_back(first);
      exp_q.push_back(~first);
      last_served = ~first;
    end else if (r0) begin
      exp_q.push_back(1'b0);
      last_served = 1'b0;
    end else if (r1) begin
      exp_q.push_back(1'b1);
      last_served = 1'b1;
    end
  endtask

  // At most one termination per cycle across both masters.
  always @(negedge clk) begin
    if (!rst_i && (m0_ack_o || m1_ack_o || m0_err_o || m1_err_o))
      check_eq("one_resp", 32'(m0_ack_o) + 32'(m1_ack_o) + 32'(m0_err_o) + 32'(m1_err_o), 1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_addr_i = addr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_addr_i = addr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    last_served = 1'b1;
  endtask

  // One single-beat cycle; inputs change after the edge, outputs sampled mid-cycle.
  task automatic master_txn(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] dat, input logic [3:0] sel);
    logic done;
    logic ack, err, other_ack;
    logic [0:0] exp_m;
    done = 1'b0;
    @(posedge clk); #1;
    drive(m, 1, 1, we, addr, dat, sel);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      ack       = (m == 0) ? m0_ack_o : m1_ack_o;
      err       = (m == 0) ? m0_err_o : m1_err_o;
      other_ack = (m == 0) ? m1_ack_o : m0_ack_o;
      if (ack) begin
        done = 1'b1;
        ack_cyc[m] = cyc_cnt;
        if (exp_q.size() == 0) check_eq("order_q_size", exp_q.size(), 1);
        else begin
          exp_m = exp_q.pop_front();
          check_eq("order", m, 32'(exp_m));
        end
        check_eq("other_ack", other_ack, 0);
        check_eq("ack_addr", s_addr_o, addr);
        check_eq("ack_we", s_we_o, we);
        if (we) begin
          check_eq("wr_dat", s_dat_o, dat);
          check_eq("wr_sel", s_sel_o, sel);
          for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[addr[9:2]][8*b +: 8] = dat[8*b +: 8];
        end else begin
          check_eq("rd_dat", (m == 0) ? m0_dat_o : m1_dat_o, ref_mem[addr[9:2]]);
        end
      end else if (err) begin
        done = 1'b1;
        check_eq("unexpected_err", err, 0);
      end
    end
    if (!done) check_eq("txn_timeout", done, 1);
    @(posedge clk); #1;
    drive(m, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  pat;
    logic        we0, we1;
    logic [31:0] a0, a1, d0, d1, exp_word;
    logic [3:0]  s0, s1;
    int g, err_cnt, err_at, ack_cnt, stb_after;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    last_served = 1'b1;

    // Reset held two cycles; everything quiet.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", dbg_state, IDLE);
    check_eq("rst_s_cyc", s_cyc_o, 0);
    check_eq("rst_s_stb", s_stb_o, 0);
    check_eq("rst_s_addr", s_addr_o, 0);
    check_eq("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    @(posedge clk); #1 rst_i = 1'b0;

    // 1: m0 read, one arbitration cycle then zero-latency ack.
    lat = 0;
    drive(0, 1, 1, 0, 32'h0000_0010, 0, 4'hF);
    @(negedge clk);
    check_eq("t1_arb_cycle_s_cyc", s_cyc_o, 0);
    @(negedge clk);
    check_eq("t1_s_cyc", s_cyc_o, 1);
    check_eq("t1_s_addr", s_addr_o, 32'h0000_0010);
    check_eq("t1_m0_ack", m0_ack_o, 1);
    check_eq("t1_m1_ack", m1_ack_o, 0);
    check_eq("t1_m0_dat", m0_dat_o, init_word(4));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    last_served = 1'b0;

    // 2: simultaneous request after reset -> m0 first, m1 after one idle cycle.
    do_reset();
    expect_round(1, 1);
    fork
      master_txn(0, 0, 32'h0000_0020, 0, 4'hF);
      master_txn(1, 0, 32'h0000_0024, 0, 4'hF);
    join
    check_eq("t2_handoff_cycles", ack_cyc[1] - ack_cyc[0], 3);

    // 3: continuous contention alternates 0,1,0,1.
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(0, 2);
      expect_round(1, 1);
      fork
        master_txn(0, 0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 0, 4'hF);
        master_txn(1, 0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 0, 4'hF);
      join
    end

    // 4: m1 partial write, upper bytes preserved.
    lat = 1;
    expect_round(0, 1);
    master_txn(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011);
    exp_word = init_word(8'h40);
    exp_word[15:0] = 16'hBEEF;
    check_eq("t4_ram_word", mem[8'h40], exp_word);

    // Randomized rounds against the reference model.
    for (int r = 0; r < 30; r++) begin
      pat = 2'($urandom_range(1, 3));
      lat = $urandom_range(0, 2);
      we0 = 1'($urandom); we1 = 1'($urandom);
      a0 = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      a1 = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d0 = $urandom; d1 = $urandom;
      s0 = 4'($urandom_range(1, 15)); s1 = 4'($urandom_range(1, 15));
      expect_round(pat[0], pat[1]);
      fork
        if (pat[0]) master_txn(0, we0, a0, d0, s0);
        if (pat[1]) master_txn(1, we1, a1, d1, s1);
      join
    end

    // 5: slave never acks, TIMEOUT=4 -> err on the 4th stalled cycle.
    ack_en = 1'b0;
    g = 0; err_cnt = 0; err_at = 0; ack_cnt = 0; stb_after = 0;
    @(posedge clk); #1;
    drive(0, 1, 1, 0, 32'h0000_0040, 0, 4'hF);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_cyc_o) g++;
      if (m0_ack_o) ack_cnt++;
      if (err_cnt > 0 && s_stb_o) stb_after++;
      if (m0_err_o) begin err_cnt++; err_at = g; end
    end
    check_eq("t5_err_count", err_cnt, 1);
    check_eq("t5_err_cycle", err_at, 4);
    check_eq("t5_ack_count", ack_cnt, 0);
    check_eq("t5_stb_after", stb_after, 0);
    check_eq("t5_abort_state", dbg_state, ABORT);
    check_eq("t5_abort_s_cyc", s_cyc_o, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_back_idle", dbg_state, IDLE);
    last_served = 1'b0;

    // 6: reset while m1 holds the bus with stb high.
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 32'h0000_0080, 0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_gnt1", dbg_state, GNT1);
    check_eq("t6_gnt1_s_stb", s_stb_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_m1_ack", m1_ack_o, 0);
    check_eq("t6_rst_s_cyc", s_cyc_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    last_served = 1'b1;
    @(negedge clk);
    check_eq("t6_post_s_cyc", s_cyc_o, 0);
    check_eq("t6_post_m1_ack", m1_ack_o, 0);
    check_eq("t6_post_state", dbg_state, IDLE);
    lat = 0;
    expect_round(1, 1);
    fork
      master_txn(0, 0, 32'h0000_0010, 0, 4'hF);
      master_txn(1, 0, 32'h0000_0014, 0, 4'hF);
    join

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
